// File: rtl/cmd_tx_enc.sv
// cmd_tx_enc -- transmit-side command encoder for the UART command link.
//
// Converts single-cycle button trigger pulses into ASCII command bytes
// ('R' 0x52, 'L' 0x4C, 'U' 0x55), optionally follows each one with a 0x0A
// terminator, and feeds the bytes to a UART transmitter through a
// start/busy/done handshake. One request per command can be pending; pending
// requests are served round-robin in the order R -> L -> U -> R.
//
// Parameters
//   APPEND_LF   1: send 0x0A after every command byte, 0: command bytes only
//   OVF_W       width of the saturating dropped-trigger counter
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous reset, active low
//   btn_r_trig   in   1      1-cycle pulse: request 'R'
//   btn_l_trig   in   1      1-cycle pulse: request 'L'
//   btn_u_trig   in   1      1-cycle pulse: request 'U'
//   tx_busy      in   1      UART transmitter is shifting a byte
//   tx_done      in   1      1-cycle pulse: UART finished the current byte
//   tx_start     out  1      1-cycle pulse: load tx_data into the UART
//   tx_data      out  8      byte to send, stable from tx_start until tx_done
//   pending      out  3      {U,L,R} requests waiting to be sent
//   ovf_cnt      out  OVF_W  triggers dropped because already pending
module cmd_tx_enc #(
  parameter int unsigned APPEND_LF = 1,
  parameter int unsigned OVF_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_r_trig,
  input  logic             btn_l_trig,
  input  logic             btn_u_trig,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [2:0]       pending,
  output logic [OVF_W-1:0] ovf_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CMD,
    SEND_LF,
    WAIT_LF
  } state_t;

  // Values double as bit positions in pending / grant.
  typedef enum logic [1:0] {
    CMD_R = 2'd0,
    CMD_L = 2'd1,
    CMD_U = 2'd2
  } cmd_t;

  localparam logic [7:0]  LF_BYTE = 8'h0A;
  localparam int unsigned SUM_W   = OVF_W + 2;

  function automatic cmd_t rr_succ(input cmd_t c);
    case (c)
      CMD_R:   return CMD_L;
      CMD_L:   return CMD_U;
      default: return CMD_R;
    endcase
  endfunction

  function automatic logic [7:0] cmd_ascii(input cmd_t c);
    case (c)
      CMD_R:   return 8'h52;
      CMD_L:   return 8'h4C;
      default: return 8'h55;
    endcase
  endfunction

  state_t           state;
  state_t           state_nxt;
  cmd_t             rr_ptr;
  cmd_t             rr_ptr_nxt;
  cmd_t             cand1;
  cmd_t             cand2;
  cmd_t             grant_cmd;
  logic             grant_vld;
  logic [2:0]       grant;
  logic [2:0]       trig;
  logic [2:0]       drop;
  logic [2:0]       pending_nxt;
  logic [1:0]       drop_cnt;
  logic [SUM_W-1:0] ovf_sum;
  logic [OVF_W-1:0] ovf_nxt;
  logic             tx_start_nxt;
  logic [7:0]       tx_data_nxt;

  // Round-robin pick: first pending command at or after rr_ptr.
  always_comb begin
    cand1     = rr_succ(rr_ptr);
    cand2     = rr_succ(cand1);
    grant_vld = 1'b1;
    grant_cmd = rr_ptr;
    if (pending[rr_ptr]) begin
      grant_cmd = rr_ptr;
    end else if (pending[cand1]) begin
      grant_cmd = cand1;
    end else if (pending[cand2]) begin
      grant_cmd = cand2;
    end else begin
      grant_vld = 1'b0;
    end
  end

  // Next-state logic; tx_start/tx_data are registered so their next values
  // are decided here alongside the state.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    grant        = '0;
    case (state)
      IDLE: begin
        if (grant_vld && !tx_busy) begin
          grant        = 3'b001 << grant_cmd;
          tx_start_nxt = 1'b1;
          tx_data_nxt  = cmd_ascii(grant_cmd);
          rr_ptr_nxt   = rr_succ(grant_cmd);
          state_nxt    = WAIT_CMD;
        end
      end
      WAIT_CMD: begin
        if (tx_done) begin
          state_nxt = (APPEND_LF != 0) ? SEND_LF : IDLE;
        end
      end
      SEND_LF: begin
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = LF_BYTE;
          state_nxt    = WAIT_LF;
        end
      end
      WAIT_LF: begin
        if (tx_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pending capture. A trigger arriving on the cycle its own bit is granted
  // re-arms the bit instead of counting as a drop.
  always_comb begin
    trig        = {btn_u_trig, btn_l_trig, btn_r_trig};
    drop        = trig & pending & ~grant;
    pending_nxt = (pending & ~grant) | trig;
    drop_cnt    = 2'(drop[0]) + 2'(drop[1]) + 2'(drop[2]);
    ovf_sum     = SUM_W'(ovf_cnt) + SUM_W'(drop_cnt);
    // Up to three drops per cycle; clamp at all-ones on carry-out.
    if (|ovf_sum[SUM_W-1:OVF_W]) begin
      ovf_nxt = '1;
    end else begin
      ovf_nxt = ovf_sum[OVF_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= CMD_R;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      pending  <= '0;
      ovf_cnt  <= '0;
    end else begin
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      pending  <= pending_nxt;
      ovf_cnt  <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_tx_enc.sv
module tb_cmd_tx_enc;

  localparam int UART_CYC = 4;
  localparam int LOG_MAX  = 128;

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic trig_r    = 1'b0;
  logic trig_l    = 1'b0;
  logic trig_u    = 1'b0;
  logic hold_busy = 1'b0;
  logic spur_done = 1'b0;

  // Index 0: APPEND_LF=1 instance, index 1: APPEND_LF=0 instance.
  logic [1:0]      st;
  logic [1:0][7:0] dat;
  logic [1:0][2:0] pnd;
  logic [1:0][7:0] ovf;
  logic [1:0]      ub = '0;
  logic [1:0]      ud = '0;
  logic [1:0]      busy;
  logic [1:0]      done;
  int              ucnt [2];

  int checks   = 0;
  int failures = 0;

  logic [7:0] log_mem  [2][LOG_MAX];
  int         log_n    [2];
  int         log_base [2];

  int         m_pend  [2][3];
  int         m_rr    [2];
  int         m_phase [2];
  int         m_ovf   [2];
  logic       m_start [2];
  logic [7:0] m_data  [2];

  assign busy = ub | {2{hold_busy}};
  assign done = ud | {2{spur_done}};

  always #5 clk = ~clk;

  cmd_tx_enc #(.APPEND_LF(1), .OVF_W(8)) u_dut_lf (
    .clk(clk), .rst_n(rst_n),
    .btn_r_trig(trig_r), .btn_l_trig(trig_l), .btn_u_trig(trig_u),
    .tx_busy(busy[0]), .tx_done(done[0]),
    .tx_start(st[0]), .tx_data(dat[0]), .pending(pnd[0]), .ovf_cnt(ovf[0])
  );

  cmd_tx_enc #(.APPEND_LF(0), .OVF_W(8)) u_dut_raw (
    .clk(clk), .rst_n(rst_n),
    .btn_r_trig(trig_r), .btn_l_trig(trig_l), .btn_u_trig(trig_u),
    .tx_busy(busy[1]), .tx_done(done[1]),
    .tx_start(st[1]), .tx_data(dat[1]), .pending(pnd[1]), .ovf_cnt(ovf[1])
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endfunction

  function automatic logic [7:0] ascii_of(input int c);
    case (c)
      0:       return 8'h52;
      1:       return 8'h4C;
      default: return 8'h55;
    endcase
  endfunction

  // UART stand-in: busy for UART_CYC cycles after tx_start, then a done pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ub[k] = 1'b0; ud[k] = 1'b0; ucnt[k] = 0;
      end else begin
        ud[k] = 1'b0;
        if (ucnt[k] > 1) begin
          ucnt[k]--;
        end else if (ucnt[k] == 1) begin
          ucnt[k] = 0; ub[k] = 1'b0; ud[k] = 1'b1;
        end else if (st[k]) begin
          ub[k] = 1'b1; ucnt[k] = UART_CYC;
        end
      end
    end
  end

  // Reference model. Link phase: 0 free, 1 command byte out,
  // 2 terminator owed, 3 terminator out.
  always @(posedge clk or negedge rst_n) begin : model
    int g;
    int t [3];
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_rr[k] = 0; m_phase[k] = 0; m_ovf[k] = 0;
        m_start[k] = 1'b0; m_data[k] = 8'h00;
        for (int j = 0; j < 3; j++) m_pend[k][j] = 0;
      end
    end else begin
      t[0] = int'(trig_r); t[1] = int'(trig_l); t[2] = int'(trig_u);
      for (int k = 0; k < 2; k++) begin
        g = -1;
        m_start[k] = 1'b0;
        case (m_phase[k])
          0: if (!busy[k]) begin
               for (int j = 0; j < 3; j++)
                 if (g < 0 && m_pend[k][(m_rr[k] + j) % 3] != 0) g = (m_rr[k] + j) % 3;
               if (g >= 0) begin
                 m_start[k] = 1'b1; m_data[k] = ascii_of(g);
                 m_rr[k] = (g + 1) % 3; m_phase[k] = 1;
               end
             end
          1: if (done[k]) m_phase[k] = (k == 0) ? 2 : 0;
          2: if (!busy[k]) begin
               m_start[k] = 1'b1; m_data[k] = 8'h0A; m_phase[k] = 3;
             end
          default: if (done[k]) m_phase[k] = 0;
        endcase
        for (int j = 0; j < 3; j++) begin
          if (t[j] != 0) begin
            if (m_pend[k][j] != 0 && g != j) m_ovf[k] = (m_ovf[k] < 255) ? m_ovf[k] + 1 : 255;
            m_pend[k][j] = 1;
          end else if (g == j) begin
            m_pend[k][j] = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of transmitted bytes.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("tx_start_i%0d", k), 32'(st[k]), 32'(m_start[k]));
        check($sformatf("tx_data_i%0d", k), 32'(dat[k]), 32'(m_data[k]));
        check($sformatf("pending_i%0d", k), 32'(pnd[k]),
              32'({m_pend[k][2] != 0, m_pend[k][1] != 0, m_pend[k][0] != 0}));
        check($sformatf("ovf_cnt_i%0d", k), 32'(ovf[k]), 32'(m_ovf[k]));
        if (st[k]) begin
          if (log_n[k] < LOG_MAX) log_mem[k][log_n[k]] = dat[k];
          log_n[k]++;
        end
      end
    end
  end

  function automatic bit all_idle();
    for (int k = 0; k < 2; k++) begin
      if (m_phase[k] != 0 || m_pend[k][0] != 0 || m_pend[k][1] != 0 ||
          m_pend[k][2] != 0 || ucnt[k] != 0 || st[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Bytes sent since the last marker against a hand-written list packed
  // first-byte-most-significant.
  function automatic void check_log(input int k, input string name, input int n,
                                    input logic [63:0] expv);
    int got;
    logic [31:0] act;
    got = log_n[k] - log_base[k];
    check($sformatf("%s_count_i%0d", name, k), 32'(got), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got && log_base[k] + i < LOG_MAX) act = 32'(log_mem[k][log_base[k] + i]);
      else act = 32'hFFFF_FFFF;
      check($sformatf("%s_i%0d_byte%0d", name, k, i), act, 32'(expv[8*(n-1-i) +: 8]));
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic r, input logic l, input logic u);
    @(negedge clk);
    trig_r = r; trig_l = l; trig_u = u;
    @(negedge clk);
    trig_r = 1'b0; trig_l = 1'b0; trig_u = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    trig_r = 1'b0; trig_l = 1'b0; trig_u = 1'b0;
    hold_busy = 1'b0; spur_done = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    log_base[0] = log_n[0];
    log_base[1] = log_n[1];
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !all_idle()) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(n < budget), 32'd1);
    cyc(2);
  endtask

  task automatic wait_start(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !st[0]) begin
      @(negedge clk);
      n++;
    end
    check({name, "_start_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    log_n[0] = 0; log_n[1] = 0; log_base[0] = 0; log_base[1] = 0;

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_tx_start_i%0d", k), 32'(st[k]), 32'd0);
      check($sformatf("rst_tx_data_i%0d", k), 32'(dat[k]), 32'h00);
      check($sformatf("rst_pending_i%0d", k), 32'(pnd[k]), 32'd0);
      check($sformatf("rst_ovf_i%0d", k), 32'(ovf[k]), 32'd0);
    end
    cyc(2);
    rst_n = 1'b1;

    // Single R: two-edge latency, then terminator on the LF instance.
    do_reset();
    @(negedge clk); trig_r = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("lat1_start_i%0d", k), 32'(st[k]), 32'd0);
      check($sformatf("lat1_pending_i%0d", k), 32'(pnd[k]), 32'b001);
    end
    @(negedge clk); trig_r = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("lat2_start_i%0d", k), 32'(st[k]), 32'd1);
      check($sformatf("lat2_data_i%0d", k), 32'(dat[k]), 32'h52);
      check($sformatf("lat2_pending_i%0d", k), 32'(pnd[k]), 32'b000);
    end
    wait_idle("single_r", 200);
    check_log(0, "single_r", 2, 64'h520A);
    check_log(1, "single_r", 1, 64'h52);

    // R, L, U in one cycle.
    do_reset();
    pulse(1'b1, 1'b1, 1'b1);
    wait_idle("rlu", 300);
    check_log(0, "rlu", 6, 64'h520A_4C0A_550A);
    check_log(1, "rlu", 3, 64'h52_4C55);
    check("rlu_ovf_i0", 32'(ovf[0]), 32'd0);
    check("rlu_ovf_i1", 32'(ovf[1]), 32'd0);

    // Fairness: R and U arrive while L is in flight; pointer sits at U.
    do_reset();
    pulse(1'b0, 1'b1, 1'b0);
    wait_start("fair", 20);
    cyc(1);
    pulse(1'b1, 1'b0, 1'b1);
    wait_idle("fair", 300);
    check_log(0, "fair", 6, 64'h4C0A_550A_520A);
    check_log(1, "fair", 3, 64'h4C_5552);

    // Busy held: R once and U three times -> two drops, nothing sent.
    do_reset();
    hold_busy = 1'b1;
    pulse(1'b1, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    cyc(10);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("hold_ovf_i%0d", k), 32'(ovf[k]), 32'd2);
      check($sformatf("hold_pending_i%0d", k), 32'(pnd[k]), 32'b101);
    end
    check_log(0, "hold", 0, 64'h0);
    check_log(1, "hold", 0, 64'h0);
    hold_busy = 1'b0;
    wait_idle("hold", 300);
    check_log(0, "hold_rel", 4, 64'h520A_550A);
    check_log(1, "hold_rel", 2, 64'h5255);
    check("hold_rel_ovf_i0", 32'(ovf[0]), 32'd2);

    // Spurious done while idle changes nothing.
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    cyc(6);
    check_log(0, "spur", 4, 64'h520A_550A);
    check_log(1, "spur", 2, 64'h5255);
    check("spur_pending_i1", 32'(pnd[1]), 32'd0);

    // Saturation: 1 capture + 300 drops.
    do_reset();
    hold_busy = 1'b1;
    trig_r = 1'b1;
    cyc(301);
    trig_r = 1'b0;
    cyc(1);
    check("sat_ovf_i0", 32'(ovf[0]), 32'hFF);
    check("sat_ovf_i1", 32'(ovf[1]), 32'hFF);
    hold_busy = 1'b0;
    wait_idle("sat", 200);
    check_log(1, "sat", 1, 64'h52);
    check("sat_after_ovf_i1", 32'(ovf[1]), 32'hFF);

    // Trigger on the grant cycle re-arms without a drop.
    do_reset();
    trig_r = 1'b1;
    cyc(2);
    trig_r = 1'b0;
    wait_idle("rearm", 300);
    check_log(0, "rearm", 4, 64'h520A_520A);
    check_log(1, "rearm", 2, 64'h5252);
    check("rearm_ovf_i0", 32'(ovf[0]), 32'd0);
    check("rearm_ovf_i1", 32'(ovf[1]), 32'd0);

    // Reset mid-transfer clears everything; no start afterwards.
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    wait_start("midrst", 20);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check("midrst_pre_ovf_i0", 32'(ovf[0]), 32'd1);
    check("midrst_pre_ovf_i1", 32'(ovf[1]), 32'd1);
    check("midrst_pre_data_i1", 32'(dat[1]), 32'h52);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_start_i%0d", k), 32'(st[k]), 32'd0);
      check($sformatf("midrst_data_i%0d", k), 32'(dat[k]), 32'h00);
      check($sformatf("midrst_pending_i%0d", k), 32'(pnd[k]), 32'd0);
      check($sformatf("midrst_ovf_i%0d", k), 32'(ovf[k]), 32'd0);
    end
    cyc(3);
    log_base[0] = log_n[0];
    log_base[1] = log_n[1];
    rst_n = 1'b1;
    cyc(30);
    check_log(0, "post_rst", 0, 64'h0);
    check_log(1, "post_rst", 0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
